// File: rtl/fe_ic_arb.sv
// fe_ic_arb: shares one IC request port among NUM_REQ front-end requesters, remapping ids to internal tags.
// Optional saturating perf counters are built when FE_IC_ARB_PERF_EN is defined.
package fe_ic_arb_pkg;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 8;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [ID_W-1:0]   id;
  } t_mem_req_pkt;

  typedef struct packed {
    logic              valid;
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
  } t_mem_rsp_pkt;
endpackage

module fe_ic_arb
  import fe_ic_arb_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int MAX_OUTST    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         rq_req_valid,
  input  t_mem_req_pkt [NUM_REQ-1:0] rq_req_pkt,
  output logic [NUM_REQ-1:0]         rq_req_gn,
  output t_mem_rsp_pkt [NUM_REQ-1:0] rq_rsp_pkt,
  input  logic                       flush,
  output t_mem_req_pkt               fb_ic_req_nnn,
  input  logic                       ic_fb_req_rdy,
  input  t_mem_rsp_pkt               ic_fb_rsp_nnn,
  output logic                       arb_err
`ifdef FE_IC_ARB_PERF_EN
  ,
  output logic [31:0]                perf_grants [NUM_REQ],
  output logic [31:0]                perf_full_cyc,
  output logic [31:0]                perf_drop
`endif
);

  localparam int TAG_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [MAX_OUTST-1:0] r_busy;
  logic [MAX_OUTST-1:0] r_drop;
  logic [OWN_W-1:0]     r_owner   [MAX_OUTST];
  logic [ID_W-1:0]      r_orig_id [MAX_OUTST];
  logic [OWN_W-1:0]     r_rr_ptr;
  logic [CNT_W-1:0]     r_starve  [NUM_REQ];
  t_mem_rsp_pkt [NUM_REQ-1:0] r_rsp_pkt;
  logic                 r_err;

  logic             w_any_free;
  logic [TAG_W-1:0] w_free_tag;
  logic             w_can_grant;
  logic             w_gnt_any;
  logic [OWN_W-1:0] w_gnt_idx;
  logic [TAG_W-1:0] w_rsp_tag;
  logic             w_rsp_hit;
  logic             w_rsp_fwd;
  logic             w_rsp_drop;
  logic             w_unused_pkt_valid;

  function automatic logic [OWN_W-1:0] rr_idx(input logic [OWN_W-1:0] ptr, input int k);
    return OWN_W'(((int'(ptr) - 1 + k) % (NUM_REQ - 1)) + 1);
  endfunction

  // Lowest free tag comes from the registered busy vector, so a tag freed this cycle is not reused yet.
  always_comb begin
    w_any_free = 1'b0;
    w_free_tag = '0;
    for (int t = MAX_OUTST - 1; t >= 0; t--) begin
      if (!r_busy[t]) begin
        w_any_free = 1'b1;
        w_free_tag = TAG_W'(t);
      end
    end
  end

  assign w_can_grant = ic_fb_req_rdy && w_any_free && !flush;

  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    if (w_can_grant) begin
      for (int i = NUM_REQ - 1; i >= 1; i--) begin
        if (rq_req_valid[i] && r_starve[i] == CNT_W'(STARVE_LIMIT)) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = OWN_W'(i);
        end
      end
      if (!w_gnt_any && rq_req_valid[0]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = '0;
      end
      if (!w_gnt_any) begin
        for (int k = NUM_REQ - 2; k >= 0; k--) begin
          if (rq_req_valid[rr_idx(r_rr_ptr, k)]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = rr_idx(r_rr_ptr, k);
          end
        end
      end
    end
  end

  assign rq_req_gn = w_gnt_any ? (NUM_REQ'(1) << w_gnt_idx) : '0;

  always_comb begin
    fb_ic_req_nnn = '0;
    if (w_gnt_any) begin
      fb_ic_req_nnn.valid = 1'b1;
      fb_ic_req_nnn.addr  = rq_req_pkt[w_gnt_idx].addr;
      fb_ic_req_nnn.id    = ID_W'(w_free_tag);
    end
  end

  always_comb begin
    w_unused_pkt_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_unused_pkt_valid = w_unused_pkt_valid ^ rq_req_pkt[i].valid;
    end
  end

  // Ids outside the table range count as unallocated tags.
  assign w_rsp_tag  = ic_fb_rsp_nnn.id[TAG_W-1:0];
  assign w_rsp_hit  = ic_fb_rsp_nnn.valid && (ic_fb_rsp_nnn.id < ID_W'(MAX_OUTST)) && r_busy[w_rsp_tag];
  assign w_rsp_fwd  = w_rsp_hit && !r_drop[w_rsp_tag] && !flush;
  assign w_rsp_drop = ic_fb_rsp_nnn.valid && !w_rsp_fwd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
      r_drop <= '0;
      for (int t = 0; t < MAX_OUTST; t++) begin
        r_owner[t]   <= '0;
        r_orig_id[t] <= '0;
      end
    end else begin
      if (flush) r_drop <= r_drop | r_busy;
      if (w_rsp_hit) r_busy[w_rsp_tag] <= 1'b0;
      if (w_gnt_any) begin
        r_busy[w_free_tag]    <= 1'b1;
        r_drop[w_free_tag]    <= 1'b0;
        r_owner[w_free_tag]   <= w_gnt_idx;
        r_orig_id[w_free_tag] <= rq_req_pkt[w_gnt_idx].id;
      end
    end
  end

  // Pointer only moves on secondary grants; requester 0 never owns a starve counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr <= OWN_W'(1);
      for (int i = 0; i < NUM_REQ; i++) r_starve[i] <= '0;
    end else begin
      if (w_gnt_any && w_gnt_idx != '0) begin
        r_rr_ptr <= (w_gnt_idx == OWN_W'(NUM_REQ - 1)) ? OWN_W'(1) : w_gnt_idx + OWN_W'(1);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == 0 || !rq_req_valid[i] || (w_gnt_any && w_gnt_idx == OWN_W'(i))) begin
          r_starve[i] <= '0;
        end else if (r_starve[i] != CNT_W'(STARVE_LIMIT)) begin
          r_starve[i] <= r_starve[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_pkt <= '0;
      r_err     <= 1'b0;
    end else begin
      r_rsp_pkt <= '0;
      if (w_rsp_fwd) begin
        r_rsp_pkt[r_owner[w_rsp_tag]].valid <= 1'b1;
        r_rsp_pkt[r_owner[w_rsp_tag]].id    <= r_orig_id[w_rsp_tag];
        r_rsp_pkt[r_owner[w_rsp_tag]].data  <= ic_fb_rsp_nnn.data;
      end
      if (ic_fb_rsp_nnn.valid && !w_rsp_hit) r_err <= 1'b1;
    end
  end

  assign rq_rsp_pkt = r_rsp_pkt;
  assign arb_err    = r_err;

`ifdef FE_IC_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) perf_grants[i] <= '0;
      perf_full_cyc <= '0;
      perf_drop     <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_gnt_any && w_gnt_idx == OWN_W'(i) && perf_grants[i] != '1) begin
          perf_grants[i] <= perf_grants[i] + 32'd1;
        end
      end
      if ((|rq_req_valid) && ic_fb_req_rdy && !flush && !w_any_free && perf_full_cyc != '1) begin
        perf_full_cyc <= perf_full_cyc + 32'd1;
      end
      if (w_rsp_drop && perf_drop != '1) perf_drop <= perf_drop + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fe_ic_arb.sv
// tb_fe_ic_arb: scoreboard bench for fe_ic_arb; a NUM_REQ=4 instance covers secondary round-robin order.
// Responses are predicted into a queue when driven and compared by a negedge monitor.
module tb_fe_ic_arb;
  import fe_ic_arb_pkg::*;

  logic clk;
  logic reset;
  logic [1:0] rqValid;
  t_mem_req_pkt [1:0] rqPkt;
  logic [1:0] gn;
  t_mem_rsp_pkt [1:0] rspPkt;
  logic flush;
  t_mem_req_pkt icReq;
  logic icRdy;
  t_mem_rsp_pkt icRsp;
  logic arbErr;

  logic [3:0] valid4;
  t_mem_req_pkt [3:0] pkt4;
  logic [3:0] gn4;
  t_mem_rsp_pkt [3:0] rsp4;
  t_mem_req_pkt icReq4;
  t_mem_rsp_pkt icRsp4;
  logic err4;

`ifdef FE_IC_ARB_PERF_EN
  logic [31:0] perfGrants [2];
  logic [31:0] perfFull, perfDrop;
  logic [31:0] perfGrants4 [4];
  logic [31:0] perfFull4, perfDrop4;
`endif

  int testsRun = 0;
  int testsFailed = 0;
  int cycleCnt = 0;

  typedef struct {
    int          due;
    int          owner;
    logic [7:0]  id;
    logic [31:0] data;
  } expRsp_t;
  expRsp_t rspQ[$];

  logic        mBusy [4];
  logic        mDrop [4];
  int          mOwner [4];
  logic [7:0]  mOrig [4];

  fe_ic_arb #(.NUM_REQ(2), .MAX_OUTST(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset), .rq_req_valid(rqValid), .rq_req_pkt(rqPkt),
    .rq_req_gn(gn), .rq_rsp_pkt(rspPkt), .flush(flush), .fb_ic_req_nnn(icReq),
    .ic_fb_req_rdy(icRdy), .ic_fb_rsp_nnn(icRsp), .arb_err(arbErr)
`ifdef FE_IC_ARB_PERF_EN
    , .perf_grants(perfGrants), .perf_full_cyc(perfFull), .perf_drop(perfDrop)
`endif
  );

  fe_ic_arb #(.NUM_REQ(4), .MAX_OUTST(4), .STARVE_LIMIT(8)) dut4 (
    .clk(clk), .reset(reset), .rq_req_valid(valid4), .rq_req_pkt(pkt4),
    .rq_req_gn(gn4), .rq_rsp_pkt(rsp4), .flush(1'b0), .fb_ic_req_nnn(icReq4),
    .ic_fb_req_rdy(1'b1), .ic_fb_rsp_nnn(icRsp4), .arb_err(err4)
`ifdef FE_IC_ARB_PERF_EN
    , .perf_grants(perfGrants4), .perf_full_cyc(perfFull4), .perf_drop(perfDrop4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt = cycleCnt + 1;

  // Every cycle out of reset, each requester's response port must match the front queue entry due now, else be idle.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      for (int r = 0; r < 2; r++) begin
        if (rspQ.size() > 0 && rspQ[0].due == cycleCnt && rspQ[0].owner == r) begin
          expRsp_t e;
          t_mem_rsp_pkt expPkt;
          e = rspQ.pop_front();
          expPkt = {1'b1, e.id, e.data};
          testsRun++;
          if (rspPkt[r] !== expPkt) begin
            testsFailed++;
            $display("[TB] FAIL rsp_route req%0d got=%h exp=%h", r, rspPkt[r], expPkt);
          end
        end else begin
          testsRun++;
          if (rspPkt[r].valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL rsp_idle req%0d got valid=%b exp valid=0", r, rspPkt[r].valid);
          end
        end
      end
    end
  end

  function automatic int lowestFree();
    for (int k = 0; k < 4; k++) if (!mBusy[k]) return k;
    return -1;
  endfunction

  task automatic clearModel();
    rspQ.delete();
    for (int k = 0; k < 4; k++) begin
      mBusy[k] = 1'b0; mDrop[k] = 1'b0; mOwner[k] = 0; mOrig[k] = 8'h00;
    end
  endtask

  task automatic clearInputs();
    rqValid = '0; rqPkt = '0; flush = 1'b0; icRdy = 1'b1; icRsp = '0;
    valid4 = '0; pkt4 = '0; icRsp4 = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    clearInputs();
    clearModel();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic driveCycle(input logic [1:0] v, input logic [7:0] id0, input logic [31:0] a0,
                            input logic [7:0] id1, input logic [31:0] a1, input logic rdy,
                            input logic fl, input logic rv, input int rtag, input logic [31:0] rd);
    @(negedge clk);
    rqValid  = v;
    rqPkt[0] = {v[0], a0, id0};
    rqPkt[1] = {v[1], a1, id1};
    icRdy    = rdy;
    flush    = fl;
    icRsp    = {rv, 8'(rtag), rd};
    #1;
  endtask

  // Advance the reference tag table across the coming clock edge.
  task automatic modelCycle(input logic gv, input int owner, input logic [7:0] oid, input logic fl,
                            input logic rv, input int rtag, input logic [31:0] rd);
    int t;
    t = lowestFree();
    if (rv && rtag >= 0 && rtag < 4 && mBusy[rtag]) begin
      if (!mDrop[rtag] && !fl) rspQ.push_back('{cycleCnt + 1, mOwner[rtag], mOrig[rtag], rd});
      mBusy[rtag] = 1'b0;
    end
    if (fl) for (int k = 0; k < 4; k++) if (mBusy[k]) mDrop[k] = 1'b1;
    if (gv && t >= 0) begin
      mBusy[t] = 1'b1; mDrop[t] = 1'b0; mOwner[t] = owner; mOrig[t] = oid;
    end
  endtask

  task automatic idleCycle(input logic rv, input int rtag, input logic [31:0] rd);
    driveCycle(2'b00, 8'h00, 32'h0, 8'h00, 32'h0, 1'b1, 1'b0, rv, rtag, rd);
    modelCycle(1'b0, 0, 8'h00, 1'b0, rv, rtag, rd);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    clearInputs();
    clearModel();
    @(negedge clk);
    testsRun++;
    if (gn !== 2'b00) begin testsFailed++; $display("[TB] FAIL reset_gn got=%b exp=00", gn); end
    testsRun++;
    if (rspPkt !== '0) begin testsFailed++; $display("[TB] FAIL reset_rsp got=%h exp=0", rspPkt); end
    testsRun++;
    if (icReq !== '0) begin testsFailed++; $display("[TB] FAIL reset_icreq got=%h exp=0", icReq); end
    testsRun++;
    if (arbErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_err got=%b exp=0", arbErr); end
    testsRun++;
    if (gn4 !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_gn4 got=%b exp=0000", gn4); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_starvation();
    int lastTag, expTag, own;
    logic [1:0] expGn;
    logic [7:0] expId;
    logic [31:0] expAddr;
    t_mem_req_pkt expReq;
    doReset();
    lastTag = -1;
    for (int c = 0; c < 10; c++) begin
      driveCycle(2'b11, 8'(c), 32'h1000 + 32'(c), 8'h41, 32'h2000, 1'b1, 1'b0,
                 lastTag >= 0, lastTag, 32'hA000 + 32'(c));
      expTag  = lowestFree();
      own     = (c == 8) ? 1 : 0;
      expGn   = (c == 8) ? 2'b10 : 2'b01;
      expId   = (c == 8) ? 8'h41 : 8'(c);
      expAddr = (c == 8) ? 32'h2000 : 32'h1000 + 32'(c);
      expReq  = {1'b1, expAddr, 8'(expTag)};
      testsRun++;
      if (gn !== expGn) begin
        testsFailed++; $display("[TB] FAIL starve_gn c=%0d got=%b exp=%b", c, gn, expGn);
      end
      testsRun++;
      if (icReq !== expReq) begin
        testsFailed++; $display("[TB] FAIL starve_icreq c=%0d got=%h exp=%h", c, icReq, expReq);
      end
      modelCycle(1'b1, own, expId, 1'b0, lastTag >= 0, lastTag, 32'hA000 + 32'(c));
      lastTag = expTag;
    end
    idleCycle(1'b1, lastTag, 32'hA0FF);
    idleCycle(1'b0, 0, 32'h0);
  endtask

  task automatic test_full();
    int expTags [7] = '{0, 1, 2, 3, 0, 0, 2};
    logic expG;
    for (int c = 0; c < 7; c++) begin
      driveCycle(2'b10, 8'h00, 32'h0, 8'h30 + 8'(c), 32'h3000 + 32'(c * 4), 1'b1, 1'b0,
                 c == 5, 2, 32'hB2);
      expG = (c < 4 || c == 6);
      testsRun++;
      if (gn !== (expG ? 2'b10 : 2'b00)) begin
        testsFailed++; $display("[TB] FAIL full_gn c=%0d got=%b exp=%b", c, gn, expG ? 2'b10 : 2'b00);
      end
      testsRun++;
      if (icReq.valid !== expG) begin
        testsFailed++; $display("[TB] FAIL full_valid c=%0d got=%b exp=%b", c, icReq.valid, expG);
      end
      if (expG) begin
        testsRun++;
        if (icReq.id !== 8'(expTags[c])) begin
          testsFailed++; $display("[TB] FAIL full_tag c=%0d got=%0d exp=%0d", c, icReq.id, expTags[c]);
        end
      end
      modelCycle(expG, 1, 8'h30 + 8'(c), 1'b0, c == 5, 2, 32'hB2);
    end
    // Free table but IC not ready: no grant.
    for (int k = 0; k < 4; k++) idleCycle(1'b1, k, 32'hC000 + 32'(k));
    driveCycle(2'b01, 8'h07, 32'h700, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    testsRun++;
    if (gn !== 2'b00 || icReq.valid !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL notrdy_gn got=%b/%b exp=00/0", gn, icReq.valid);
    end
    modelCycle(1'b0, 0, 8'h00, 1'b0, 1'b0, 0, 32'h0);
    idleCycle(1'b0, 0, 32'h0);
  endtask

  task automatic test_reorder();
    doReset();
    driveCycle(2'b01, 8'd5, 32'h500, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    testsRun++;
    if (gn !== 2'b01 || icReq.id !== 8'd0) begin
      testsFailed++; $display("[TB] FAIL reorder_first got gn=%b tag=%0d exp gn=01 tag=0", gn, icReq.id);
    end
    modelCycle(1'b1, 0, 8'd5, 1'b0, 1'b0, 0, 32'h0);
    driveCycle(2'b01, 8'd9, 32'h900, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 0, 32'h0);
    testsRun++;
    if (gn !== 2'b01 || icReq.id !== 8'd1) begin
      testsFailed++; $display("[TB] FAIL reorder_second got gn=%b tag=%0d exp gn=01 tag=1", gn, icReq.id);
    end
    modelCycle(1'b1, 0, 8'd9, 1'b0, 1'b0, 0, 32'h0);
    idleCycle(1'b1, 1, 32'hD1D1);
    idleCycle(1'b1, 0, 32'hD0D0);
    idleCycle(1'b0, 0, 32'h0);
  endtask

  task automatic test_flush();
    int expTags [4] = '{0, 1, 2, 3};
    doReset();
    for (int c = 0; c < 3; c++) begin
      driveCycle(2'b01, 8'h10 + 8'(c), 32'h100 + 32'(c), 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 0, 32'h0);
      testsRun++;
      if (icReq.id !== 8'(expTags[c])) begin
        testsFailed++; $display("[TB] FAIL flush_fill c=%0d got=%0d exp=%0d", c, icReq.id, expTags[c]);
      end
      modelCycle(1'b1, 0, 8'h10 + 8'(c), 1'b0, 1'b0, 0, 32'h0);
    end
    driveCycle(2'b01, 8'h1F, 32'h1FF, 8'h00, 32'h0, 1'b1, 1'b1, 1'b1, 0, 32'hE0);
    testsRun++;
    if (gn !== 2'b00 || icReq.valid !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL flush_gn got=%b/%b exp=00/0", gn, icReq.valid);
    end
    modelCycle(1'b0, 0, 8'h00, 1'b1, 1'b1, 0, 32'hE0);
    idleCycle(1'b1, 1, 32'hE1);
    idleCycle(1'b1, 2, 32'hE2);
    for (int c = 0; c < 4; c++) begin
      driveCycle(2'b01, 8'h20 + 8'(c), 32'h200 + 32'(c), 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 0, 32'h0);
      testsRun++;
      if (gn !== 2'b01 || icReq.id !== 8'(expTags[c])) begin
        testsFailed++; $display("[TB] FAIL flush_refill c=%0d got gn=%b tag=%0d exp gn=01 tag=%0d", c, gn, icReq.id, expTags[c]);
      end
      modelCycle(1'b1, 0, 8'h20 + 8'(c), 1'b0, 1'b0, 0, 32'h0);
    end
    testsRun++;
    if (arbErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_err got=%b exp=0", arbErr); end
    for (int k = 0; k < 4; k++) idleCycle(1'b1, k, 32'hF000 + 32'(k));
    idleCycle(1'b0, 0, 32'h0);
  endtask

  task automatic test_err();
    doReset();
    idleCycle(1'b1, 3, 32'hBAD3);
    idleCycle(1'b0, 0, 32'h0);
    testsRun++;
    if (arbErr !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_set got=%b exp=1", arbErr); end
    repeat (3) idleCycle(1'b0, 0, 32'h0);
    testsRun++;
    if (arbErr !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_sticky got=%b exp=1", arbErr); end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    testsRun++;
    if (arbErr !== 1'b0) begin testsFailed++; $display("[TB] FAIL err_clear got=%b exp=0", arbErr); end
    clearModel();
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      driveCycle(2'b01, 8'h60 + 8'(c), 32'h600, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 0, 32'h0);
      modelCycle(1'b1, 0, 8'h60 + 8'(c), 1'b0, 1'b0, 0, 32'h0);
    end
    @(negedge clk);
    clearInputs();
    #2 reset = 1'b0;
    clearModel();
    @(negedge clk);
    reset = 1'b1;
    idleCycle(1'b1, 0, 32'hDEAD);
    idleCycle(1'b0, 0, 32'h0);
    testsRun++;
    if (arbErr !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_late_rsp got=%b exp=1", arbErr); end
  endtask

  task automatic test_round_robin();
    int expIdx;
    int lastTag;
    doReset();
    lastTag = -1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      valid4 = 4'b1110;
      for (int i = 0; i < 4; i++) pkt4[i] = {1'b1, 32'h4000 + 32'(i * 16), 8'(i)};
      icRsp4 = {lastTag >= 0, 8'(lastTag), 32'h0};
      #1;
      expIdx = (c % 3) + 1;
      testsRun++;
      if (gn4 !== 4'(1 << expIdx)) begin
        testsFailed++; $display("[TB] FAIL rr_order c=%0d got=%b exp=%b", c, gn4, 4'(1 << expIdx));
      end
      testsRun++;
      if (icReq4.addr !== 32'h4000 + 32'(expIdx * 16) || icReq4.id !== 8'(c % 2)) begin
        testsFailed++; $display("[TB] FAIL rr_icreq c=%0d got=%h exp addr=%h tag=%0d", c, icReq4, 32'h4000 + 32'(expIdx * 16), c % 2);
      end
      lastTag = c % 2;
    end
    @(negedge clk);
    valid4 = '0;
    icRsp4 = {1'b1, 8'(lastTag), 32'h0};
    @(negedge clk);
    icRsp4 = '0;
  endtask

  initial begin
    reset = 1'b1;
    clearInputs();
    clearModel();
    test_reset();
    test_starvation();
    test_full();
    test_reorder();
    test_flush();
    test_err();
    test_round_robin();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/fe_ic_arb.md
Name: fe_ic_arb

Overview:
- Shares the single instruction-cache request port among NUM_REQ front-end requesters: requester 0 is the fetch-buffer demand path; 1..NUM_REQ-1 are prefetch and other secondary sources.
- Allocates an internal tag per accepted request, remaps the outgoing IC id to that tag, and routes each IC response back to its owner with the owner's original id restored.
- Sits between the fetch buffer / prefetcher and the IC.

Parameters:
- NUM_REQ, 2, number of requesters; requester 0 has demand priority.
- MAX_OUTST, 4, outstanding-tag table depth; tag width TAG_W = clog2(MAX_OUTST).
- STARVE_LIMIT, 8, consecutive denied cycles before a secondary requester is promoted.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- rq_req_valid  in  NUM_REQ  per-requester request valid.
- rq_req_pkt  in  NUM_REQ x t_mem_req_pkt  per-requester request (addr, id).
- rq_req_gn  out  NUM_REQ  one-hot grant; the request is accepted in this cycle.
- rq_rsp_pkt  out  NUM_REQ x t_mem_rsp_pkt  routed response, valid only to the owning requester.
- flush  in  1  drop all in-flight responses.
- fb_ic_req_nnn  out  t_mem_req_pkt  IC request; id = allocated tag.
- ic_fb_req_rdy  in  1  IC can accept a request this cycle.
- ic_fb_rsp_nnn  in  t_mem_rsp_pkt  IC response; id = tag.
- arb_err  out  1  sticky error: a response arrived for an unallocated tag.

Behaviour:
- Reset values: rq_req_gn=0, rq_rsp_pkt=0, fb_ic_req_nnn=0, arb_err=0, all tags free, round-robin pointer=1, starve counters=0.
- Eligibility: a grant requires rq_req_valid[i], ic_fb_req_rdy=1, at least one free tag, and flush=0.
- Arbitration, at most one grant per cycle:
  - A promoted starving secondary requester wins first; if several are promoted, the lowest index wins.
  - Otherwise requester 0 wins.
  - Otherwise the secondary requesters are picked round-robin starting at the pointer.
- Round-robin pointer: advances to (granted index + 1), wrapping 1..NUM_REQ-1. It advances only on secondary grants.
- Starvation counter (per secondary requester):
  - Increments, saturating at STARVE_LIMIT, each cycle the requester is valid and not granted.
  - Clears on its grant or when its valid is low.
  - The requester is promoted when the counter equals STARVE_LIMIT.
- Request path (combinational, same cycle as grant):
  - fb_ic_req_nnn.valid = any grant.
  - addr = granted requester's addr.
  - id = lowest free tag, computed from the registered free vector.
- Allocation: on a grant, the tag entry records {owner index, original id, drop=0}; the tag becomes busy next cycle.
- Response path (1-cycle registered latency):
  - When ic_fb_rsp_nnn.valid and the tag is busy, the next cycle drives rq_rsp_pkt[owner] = response with id = original id and valid=1; all other requesters see valid=0.
  - The tag is freed at the same edge and is allocatable from the following cycle.
  - If the entry's drop bit is set, the tag is freed but nothing is forwarded.
- Simultaneous free and allocate in one cycle: the freed tag is not reused in that cycle. With MAX_OUTST=1 this gives a maximum throughput of one request per 2 cycles.
- Unallocated-tag response: dropped, arb_err sets and stays set until reset.
- flush:
  - Sets the drop bit on every busy tag in the same cycle.
  - Suppresses all grants that cycle.
  - A response arriving in the flush cycle is also dropped.
- Full (no free tags): no grants, and fb_ic_req_nnn.valid=0.
- Empty: the table accepts up to MAX_OUTST back-to-back grants.
- Reset mid-operation: the table is cleared immediately (asynchronously); late IC responses after reset release set arb_err.

Optional Feature:
- Macro: FE_IC_ARB_PERF_EN.
- With the macro defined, the block adds these output counters, cleared on reset and saturating:
  - 32-bit perf_grants[NUM_REQ]: grants per requester.
  - 32-bit perf_full_cyc: cycles in which any request was blocked only by a full table.
  - 32-bit perf_drop: dropped responses.
- Without the macro, the counters and their ports are absent.

Test Plan:
- Both requesters valid, rdy=1, table empty for 4 cycles → grants req0 every cycle; req1 granted at cycle 8 once its starve counter hits 8, given a table kept draining.
- Only req1 valid; 4 grants with no responses → tags 0,1,2,3 issued; 5th cycle no grant, fb_ic_req_nnn.valid=0; respond tag 2 → next cycle req1 receives its original id, and tag 2 is regranted the cycle after.
- req0 issues id=5 and id=9 (tags 0,1); IC responds tag 1 then tag 0 → rq_rsp_pkt[0] shows id 9 then id 5, each 1 cycle after its response; rq_rsp_pkt[1].valid stays 0.
- 3 tags busy, flush pulsed, then responses for those tags → no forwarded responses, tags all free afterwards, arb_err=0.
- ic_fb_rsp_nnn valid with tag 3 while tag 3 is free → nothing forwarded, arb_err=1 and stays 1; reset=0 clears it.
- Secondary requesters 1,2,3 (NUM_REQ=4) continuously valid, req0 idle → grant order 1,2,3,1,2,...
